// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: mode and FSM encodings plus reset defaults for the waveform generator
package wave_gen_pkg;
  typedef enum logic [1:0] {MODE_SQUARE = 2'd0, MODE_SAW = 2'd1, MODE_TRI = 2'd2, MODE_RSVD = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_e;
  localparam mode_e MODE_RST = MODE_SQUARE;
  localparam int unsigned FREQ_RST = 0;
  function automatic int unsigned duty_rst(input int unsigned out_w);
    return 32'd1 << (out_w - 1);
  endfunction
endpackage

// File: rtl/wave_shaper.sv
// wave_shaper: combinational phase/mode/duty to sample mapping
module wave_shaper
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 12
) (
  input  logic [PHASE_W-1:0] phase,
  input  mode_e              mode,
  input  logic [OUT_W-1:0]   duty,
  output logic [OUT_W-1:0]   sample
);
  logic [OUT_W-1:0] p, q;
  assign p = phase[PHASE_W-1 -: OUT_W];
  assign q = phase[PHASE_W-2 -: OUT_W];
  assign sample = mode == MODE_SQUARE ? ((p < duty) ? {OUT_W{1'b1}} : {OUT_W{1'b0}}) :
                  mode == MODE_SAW    ? p :
                  mode == MODE_TRI    ? (phase[PHASE_W-1] ? ~q : q) : {OUT_W{1'b0}};
endmodule

// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator waveform generator with wrap-synchronised config updates
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int FREQ_W  = 18,
  parameter int OUT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [FREQ_W-1:0] cfg_freq,
  input  logic [1:0]        cfg_mode,
  input  logic [OUT_W-1:0]  cfg_duty,
  output logic              cfg_pending,
  output logic [OUT_W-1:0]  sig_out,
  output logic              wrap
);
  localparam logic [OUT_W-1:0] DUTY_RST = OUT_W'(duty_rst(OUT_W));
  state_e             state, state_n;
  logic [PHASE_W-1:0] phase, phase_n, sum;
  logic               carry;
  logic [FREQ_W-1:0]  act_freq, act_freq_n, sh_freq, sh_freq_n;
  mode_e              act_mode, act_mode_n, sh_mode, sh_mode_n;
  logic [OUT_W-1:0]   act_duty, act_duty_n, sh_duty, sh_duty_n, shape;
  assign {carry, sum} = {1'b0, phase} + (PHASE_W + 1)'(act_freq);
  assign cfg_pending = state == PEND;
  wave_shaper #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_shaper (
    .phase (phase),
    .mode  (act_mode),
    .duty  (act_duty),
    .sample(shape)
  );
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    act_freq_n = act_freq;
    act_mode_n = act_mode;
    act_duty_n = act_duty;
    sh_freq_n  = sh_freq;
    sh_mode_n  = sh_mode;
    sh_duty_n  = sh_duty;
    case (state)
      IDLE: begin
        if (cfg_load) {act_freq_n, act_mode_n, act_duty_n} = {cfg_freq, mode_e'(cfg_mode), cfg_duty};
        state_n = en ? RUN : IDLE;
      end
      default: begin
        // leaving RUN/PEND: a direct load beats any waiting shadow
        if (!en) begin
          state_n = IDLE;
          phase_n = '0;
          if (cfg_load) {act_freq_n, act_mode_n, act_duty_n} = {cfg_freq, mode_e'(cfg_mode), cfg_duty};
          else if (state == PEND) {act_freq_n, act_mode_n, act_duty_n} = {sh_freq, sh_mode, sh_duty};
        end else begin
          phase_n = sum;
          if (cfg_load && carry) begin
            {act_freq_n, act_mode_n, act_duty_n} = {cfg_freq, mode_e'(cfg_mode), cfg_duty};
            state_n = RUN;
          end else if (cfg_load) begin
            {sh_freq_n, sh_mode_n, sh_duty_n} = {cfg_freq, mode_e'(cfg_mode), cfg_duty};
            state_n = PEND;
          end else if (carry && state == PEND) begin
            {act_freq_n, act_mode_n, act_duty_n} = {sh_freq, sh_mode, sh_duty};
            state_n = RUN;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      act_freq <= FREQ_W'(FREQ_RST);
      act_mode <= MODE_RST;
      act_duty <= DUTY_RST;
      sh_freq  <= '0;
      sh_mode  <= MODE_RST;
      sh_duty  <= '0;
      sig_out  <= '0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      act_freq <= act_freq_n;
      act_mode <= act_mode_n;
      act_duty <= act_duty_n;
      sh_freq  <= sh_freq_n;
      sh_mode  <= sh_mode_n;
      sh_duty  <= sh_duty_n;
      sig_out  <= state == IDLE ? '0 : shape;
      wrap     <= state != IDLE && en && carry;
    end
  end
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: randomized and directed checks of wave_gen against a behavioural model
module tb_wave_gen;
  localparam int PW = 24;
  localparam int FW = 18;
  localparam int OW = 12;
  localparam longint MOD = longint'(1) << PW;
  logic clk = 1'b0;
  logic rst, en, cfg_load;
  logic [FW-1:0] cfg_freq;
  logic [1:0] cfg_mode;
  logic [OW-1:0] cfg_duty;
  logic cfg_pending, wrap;
  logic [OW-1:0] sig_out;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit m_run = 0, m_pend = 0, m_wrap = 0;
  longint m_phase = 0, m_sig = 0;
  int m_freq = 0, m_mode = 0, m_duty = 2048, s_freq = 0, s_mode = 0, s_duty = 0;

  wave_gen #(.PHASE_W(PW), .FREQ_W(FW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_freq(cfg_freq),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_pending(cfg_pending),
    .sig_out(sig_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic longint shape(longint ph, int mode, int duty);
    longint p, q;
    p = ph / (MOD / 4096);
    q = (ph / (MOD / 8192)) % 4096;
    case (mode)
      0: return (p < duty) ? 4095 : 0;
      1: return p;
      2: return (ph >= MOD / 2) ? 4095 - q : q;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    longint nxt;
    if (rst) begin
      m_run = 0; m_pend = 0; m_phase = 0; m_freq = 0; m_mode = 0; m_duty = 2048;
      s_freq = 0; s_mode = 0; s_duty = 0; m_sig = 0; m_wrap = 0;
    end else if (!m_run) begin
      m_sig = 0;
      m_wrap = 0;
      if (cfg_load) begin m_freq = int'(cfg_freq); m_mode = int'(cfg_mode); m_duty = int'(cfg_duty); end
      if (en) m_run = 1;
    end else begin
      m_sig = shape(m_phase, m_mode, m_duty);
      nxt = m_phase + m_freq;
      if (!en) begin
        m_wrap = 0; m_run = 0; m_phase = 0;
        if (cfg_load) begin m_freq = int'(cfg_freq); m_mode = int'(cfg_mode); m_duty = int'(cfg_duty); end
        else if (m_pend) begin m_freq = s_freq; m_mode = s_mode; m_duty = s_duty; end
        m_pend = 0;
      end else begin
        m_wrap = nxt >= MOD;
        m_phase = nxt % MOD;
        if (cfg_load && m_wrap) begin
          m_freq = int'(cfg_freq); m_mode = int'(cfg_mode); m_duty = int'(cfg_duty); m_pend = 0;
        end else if (cfg_load) begin
          s_freq = int'(cfg_freq); s_mode = int'(cfg_mode); s_duty = int'(cfg_duty); m_pend = 1;
        end else if (m_wrap && m_pend) begin
          m_freq = s_freq; m_mode = s_mode; m_duty = s_duty; m_pend = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sig_out", sig_out, m_sig);
      chk("wrap", wrap, longint'(m_wrap));
      chk("cfg_pending", cfg_pending, longint'(m_pend));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int f, input int m, input int d);
    cfg_load = 1'b1;
    cfg_freq = FW'(f);
    cfg_mode = 2'(m);
    cfg_duty = OW'(d);
  endtask

  task automatic wait_wrap(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!wrap && n < 2000);
    if (!wrap) chk("wrap_timeout", n, -1);
  endtask

  initial begin
    int n, hi, lo, wat, bad;
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_freq = '0; cfg_mode = '0; cfg_duty = '0;
    tick(); tick();
    chk("rst_sig", sig_out, 0);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_wrap", wrap, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    load(65536, 0, 2048);
    tick();
    cfg_load = 1'b0;
    en = 1'b1;
    wait_wrap(n);
    hi = 0; lo = 0; wat = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (sig_out == 12'd4095) hi++;
      else if (sig_out == 12'd0) lo++;
      if (wrap && wat == 0) wat = i;
    end
    chk("sq_high_cycles", hi, 128);
    chk("sq_low_cycles", lo, 128);
    chk("sq_period", wat, 256);
    repeat (10) tick();
    load(65536, 1, 2048);
    tick();
    cfg_load = 1'b0;
    chk("saw_pend_set", cfg_pending, 1);
    wait_wrap(n);
    chk("saw_pend_clr", cfg_pending, 0);
    bad = 0; wat = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (sig_out != OW'(16 * (i - 1))) bad++;
      if (wrap && wat == 0) wat = i;
    end
    chk("saw_steps", bad, 0);
    chk("saw_period", wat, 256);
    repeat (10) tick();
    load(65536, 2, 2048);
    tick();
    cfg_load = 1'b0;
    wait_wrap(n);
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (sig_out != OW'(i <= 128 ? 32 * (i - 1) : 4095 - 32 * (i - 129))) bad++;
    end
    chk("tri_shape", bad, 0);
    chk("tri_end_wrap", wrap, 1);
    repeat (10) tick();
    load(131072, 1, 2048);
    tick();
    cfg_load = 1'b0;
    chk("fast_pend_set", cfg_pending, 1);
    wait_wrap(n);
    wait_wrap(n);
    chk("fast_period", n, 128);
    repeat (127) tick();
    load(65536, 1, 2048);
    tick();
    cfg_load = 1'b0;
    chk("coincident_wrap", wrap, 1);
    chk("coincident_no_pend", cfg_pending, 0);
    wait_wrap(n);
    chk("coincident_period", n, 256);
    repeat (5) tick();
    load(1000, 2, 100);
    tick();
    cfg_load = 1'b0;
    chk("pend_before_rst", cfg_pending, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_sig", sig_out, 0);
    chk("rst_mid_pend", cfg_pending, 0);
    chk("rst_mid_wrap", wrap, 0);
    rst = 1'b0;
    tick(); tick();
    chk("default_duty_sig", sig_out, 4095);
    n = 0;
    repeat (300) begin
      tick();
      if (wrap) n++;
    end
    chk("zero_freq_no_wrap", n, 0);
    for (int i = 0; i < 20000; i++) begin
      int r;
      rst = ($urandom % 3000) == 0;
      en = ($urandom % 80) != 0;
      cfg_load = ($urandom % 40) == 0;
      r = $urandom % 8;
      cfg_freq = r == 0 ? '0 : r < 3 ? FW'($urandom) : FW'($urandom_range(16384, (1 << FW) - 1));
      cfg_mode = 2'($urandom);
      cfg_duty = ($urandom % 6) == 0 ? '0 : OW'($urandom);
      tick();
    end
    rst = 1'b0; cfg_load = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter PHASE_W, 24, phase accumulator width (bits).
REQ-002 Parameter FREQ_W, 18, tuning word width; SHALL be <= PHASE_W.
REQ-003 Parameter OUT_W, 12, sample width; SHALL be <= PHASE_W-1.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  run enable; high = accumulate, low = idle.
REQ-007 cfg_load  in  1  one-cycle strobe; captures cfg_freq, cfg_mode and cfg_duty.
REQ-008 cfg_freq  in  FREQ_W  tuning word; phase increment per clk, zero-extended to PHASE_W.
REQ-009 cfg_mode  in  2  0 = square, 1 = saw, 2 = triangle, 3 = reserved.
REQ-010 cfg_duty  in  OUT_W  square high-time threshold.
REQ-011 cfg_pending  out  1  shadow config waiting for phase wrap.
REQ-012 sig_out  out  OUT_W  unsigned sample, registered.
REQ-013 wrap  out  1  one-cycle pulse per completed period.

Function
REQ-014 States SHALL be IDLE, RUN and PEND, held in a registered FSM.
REQ-015 In IDLE, phase SHALL be 0 and sig_out SHALL be 0; cfg_load SHALL write the active config directly; cfg_pending SHALL be 0; en=1 SHALL go to RUN.
REQ-016 In RUN/PEND: phase <= phase + active_freq (mod 2^PHASE_W) each cycle; the carry-out SHALL define the wrap edge.
REQ-017 RUN: cfg_load without carry SHALL write the shadow, set cfg_pending and go to PEND.
REQ-018 PEND: on a carry edge, shadow -> active, clear cfg_pending, go to RUN; a further cfg_load in PEND SHALL overwrite the shadow (latest wins).
REQ-019 cfg_load on a carry edge (RUN or PEND) SHALL write the incoming config directly to active, discard the shadow and clear cfg_pending.
REQ-020 en=0 in RUN/PEND: next state IDLE, phase cleared, pending shadow applied to active, cfg_pending cleared.
REQ-021 The new config SHALL take effect on the edge after the carry edge, so there are no partial-period glitches.
REQ-022 Let P = phase[PHASE_W-1 -: OUT_W] and Q = phase[PHASE_W-2 -: OUT_W].
REQ-023 sig_out(t+1) SHALL equal f(phase(t), active mode/duty): latency of 1 cycle from the phase register.
REQ-024 Square: all-ones if P < duty, else 0; duty=0 gives constant 0.
REQ-025 Saw: P.
REQ-026 Triangle: Q if phase MSB=0, else ~Q.
REQ-027 Reserved mode: 0.
REQ-028 wrap SHALL assert exactly one cycle, on the cycle after a carry edge.
REQ-029 wrap SHALL NOT assert in IDLE.
REQ-030 cfg_freq=0 in RUN SHALL hold phase constant and never wrap; the config is then only updated via en=0 or coincident load.

Reset
REQ-031 rst SHALL take priority over all inputs.
REQ-032 rst values: state=IDLE, phase=0, active_freq=0, mode=square, duty=2^(OUT_W-1), shadow cleared, cfg_pending=0, sig_out=0, wrap=0.
REQ-033 rst asserted mid-period SHALL drop any pending config; outputs reach reset values on the first edge with rst high.

Structure
REQ-034 Package wave_gen_pkg SHALL hold the mode encodings, FSM state encodings and reset-default constants.
REQ-035 Sub-module wave_shaper SHALL hold the combinational phase/mode/duty -> sample mapping; the wave_gen top SHALL own the FSM, accumulator, shadow registers and output registers.

Verification (defaults PHASE_W=24, OUT_W=12)
REQ-036 Reset, load freq=65536/square/duty=2048, en=1 -> sig_out 4095 for 128 cycles then 0 for 128; wrap every 256 cycles.
REQ-037 Saw, freq=65536 -> sig_out steps +16 per cycle, 0..4080, then back to 0 with a wrap pulse.
REQ-038 Triangle, freq=65536 -> sig_out rises 0..4064 in steps of 32 over 128 cycles, then falls 4095..31.
REQ-039 RUN, load freq=131072 mid-period -> cfg_pending=1 until the next wrap; the period is then 128 cycles.
REQ-040 cfg_load coincident with a carry edge -> cfg_pending stays 0; the new config is active from the next period.
REQ-041 rst pulse mid-PEND -> the next cycle shows sig_out=0, cfg_pending=0, state IDLE, default duty 2048.
